// File: rtl/mwc_pkg.sv
// Shared types for the memory-write checker: FSM states and verdict fail codes.
// No logic here; latency and backpressure are properties of the modules that import it.
package mwc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } mwc_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ADDR    = 2'd1,
    FC_DATA    = 2'd2,
    FC_TIMEOUT = 2'd3
  } mwc_fail_t;

endpackage

// File: rtl/mwc_match_unit.sv
// Combinational compare of one snooped write against the expected table (in-order pointer or lowest unhit entry).
// Zero latency, no backpressure: the result is consumed by the checker in the same cycle.
module mwc_match_unit #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int NUM_EXP      = 4,
  parameter int STRICT_ORDER = 1,
  parameter int IW           = 2,
  parameter int CW           = 3
) (
  input  logic [NUM_EXP-1:0][AW-1:0] i_tbl_adr,
  input  logic [NUM_EXP-1:0][DW-1:0] i_tbl_data,
  input  logic [NUM_EXP-1:0]         i_hit_mask,
  input  logic [CW-1:0]              i_ptr,
  input  logic [AW-1:0]              i_adr,
  input  logic [DW-1:0]              i_data,
  output logic                       o_hit,
  output logic [IW-1:0]              o_idx,
  output logic                       o_data_ok
);

  always_comb begin
    o_hit     = 1'b0;
    o_idx     = '0;
    o_data_ok = 1'b0;
    if (STRICT_ORDER != 0) begin
      for (int k = 0; k < NUM_EXP; k++) begin
        if (k == int'(i_ptr)) begin
          o_idx     = IW'(k);
          o_hit     = (i_tbl_adr[k] == i_adr);
          o_data_ok = (i_tbl_data[k] == i_data);
        end
      end
    end else begin
      // Descending scan so the lowest matching unhit index is the one left standing.
      for (int k = NUM_EXP - 1; k >= 0; k--) begin
        if (!i_hit_mask[k] && (i_tbl_adr[k] == i_adr)) begin
          o_hit     = 1'b1;
          o_idx     = IW'(k);
          o_data_ok = (i_tbl_data[k] == i_data);
        end
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Snoops memory writes against a loaded expected (addr,data) table and latches a sticky PASS/FAIL verdict.
// Verdict and counters are registered (1 cycle after the deciding write); snoop-only, never backpressures.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int          AW           = 32,
  parameter int          DW           = 32,
  parameter int          NUM_EXP      = 4,
  parameter int unsigned IGNORE_ADDR  = 96,
  parameter int          TIMEOUT_CYC  = 4096,
  parameter int          STRICT_ORDER = 1,
  localparam int         IW           = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int         CW           = $clog2(NUM_EXP + 1),
  localparam int         TW           = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_idx,
  input  logic [AW-1:0] exp_adr,
  input  logic [DW-1:0] exp_data,
  input  logic          ign_en,
  input  logic          start,
  input  logic          clear,
  input  logic          mem_write,
  input  logic [AW-1:0] data_adr,
  input  logic [DW-1:0] write_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [1:0]    fail_code,
  output logic [CW-1:0] match_cnt,
  output logic [7:0]    ign_cnt,
  output logic [TW-1:0] cycle_cnt
);

  mwc_state_t                 r_state;
  mwc_state_t                 w_state_nxt;
  mwc_fail_t                  r_fail_code;
  mwc_fail_t                  w_fc_nxt;
  logic [NUM_EXP-1:0][AW-1:0] r_tbl_adr;
  logic [NUM_EXP-1:0][DW-1:0] r_tbl_data;
  logic [NUM_EXP-1:0]         r_hit_mask;
  logic [CW-1:0]              r_match_cnt;
  logic [7:0]                 r_ign_cnt;
  logic [TW-1:0]              r_cycle_cnt;

  logic          w_hit;
  logic [IW-1:0] w_idx;
  logic          w_data_ok;
  logic          w_wr;
  logic          w_ign_wr;
  logic          w_match;
  logic          w_bad;
  logic          w_last;
  logic          w_tmo;

  mwc_match_unit #(
    .AW          (AW),
    .DW          (DW),
    .NUM_EXP     (NUM_EXP),
    .STRICT_ORDER(STRICT_ORDER),
    .IW          (IW),
    .CW          (CW)
  ) u_match (
    .i_tbl_adr (r_tbl_adr),
    .i_tbl_data(r_tbl_data),
    .i_hit_mask(r_hit_mask),
    .i_ptr     (r_match_cnt),
    .i_adr     (data_adr),
    .i_data    (write_data),
    .o_hit     (w_hit),
    .o_idx     (w_idx),
    .o_data_ok (w_data_ok)
  );

  assign w_wr     = (r_state == ARMED) && mem_write;
  assign w_ign_wr = w_wr && ign_en && (data_adr == AW'(IGNORE_ADDR));
  assign w_match  = w_wr && !w_ign_wr && w_hit && w_data_ok;
  assign w_bad    = w_wr && !w_ign_wr && !(w_hit && w_data_ok);
  assign w_last   = w_match && (r_match_cnt == CW'(NUM_EXP - 1));
  assign w_tmo    = (r_state == ARMED) && (r_cycle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A completing match outranks both a timeout and nothing else can fire with it.
  always_comb begin
    w_state_nxt = r_state;
    w_fc_nxt    = FC_NONE;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (start) w_state_nxt = ARMED;
        ARMED: begin
          if (w_last) begin
            w_state_nxt = PASS;
          end else if (w_bad) begin
            w_state_nxt = FAIL;
            w_fc_nxt    = w_hit ? FC_DATA : FC_ADDR;
          end else if (w_tmo) begin
            w_state_nxt = FAIL;
            w_fc_nxt    = FC_TIMEOUT;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Table has no reset: it must survive reset and clear, and is loaded before use.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && exp_we && !clear) begin
      for (int k = 0; k < NUM_EXP; k++) begin
        if (exp_idx == IW'(k)) begin
          r_tbl_adr[k]  <= exp_adr;
          r_tbl_data[k] <= exp_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fail_code <= FC_NONE;
      r_hit_mask  <= '0;
      r_match_cnt <= '0;
      r_ign_cnt   <= '0;
      r_cycle_cnt <= '0;
    end else if (clear || ((r_state == IDLE) && start)) begin
      r_fail_code <= FC_NONE;
      r_hit_mask  <= '0;
      r_match_cnt <= '0;
      r_ign_cnt   <= '0;
      r_cycle_cnt <= '0;
    end else if (r_state == ARMED) begin
      r_cycle_cnt <= r_cycle_cnt + TW'(1);
      if (w_ign_wr && (r_ign_cnt != 8'hFF)) r_ign_cnt <= r_ign_cnt + 8'd1;
      if (w_match) begin
        r_match_cnt <= r_match_cnt + CW'(1);
        for (int k = 0; k < NUM_EXP; k++) begin
          if (w_idx == IW'(k)) r_hit_mask[k] <= 1'b1;
        end
      end
      if (w_state_nxt == FAIL) r_fail_code <= w_fc_nxt;
    end
  end

  assign busy      = (r_state == ARMED);
  assign done      = (r_state == PASS) || (r_state == FAIL);
  assign pass      = (r_state == PASS);
  assign fail_code = r_fail_code;
  assign match_cnt = r_match_cnt;
  assign ign_cnt   = r_ign_cnt;
  assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: four configurations share one stimulus bus.
// u1 NUM_EXP=1 strict, u2 NUM_EXP=2 strict, u3 NUM_EXP=2 any-order, u4 NUM_EXP=1 with a 16-cycle timeout.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exp_we = 1'b0;
  logic [0:0]  exp_idx = '0;
  logic [31:0] exp_adr = '0;
  logic [31:0] exp_data = '0;
  logic        ign_en = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_adr = '0;
  logic [31:0] write_data = '0;

  logic busy1, done1, pass1; logic [1:0] fc1; logic [0:0] mc1; logic [7:0] ic1; logic [12:0] cc1;
  logic busy2, done2, pass2; logic [1:0] fc2; logic [1:0] mc2; logic [7:0] ic2; logic [12:0] cc2;
  logic busy3, done3, pass3; logic [1:0] fc3; logic [1:0] mc3; logic [7:0] ic3; logic [12:0] cc3;
  logic busy4, done4, pass4; logic [1:0] fc4; logic [0:0] mc4; logic [7:0] ic4; logic [4:0]  cc4;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.NUM_EXP(1), .STRICT_ORDER(1)) u1 (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
    .ign_en(ign_en), .start(start), .clear(clear), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .busy(busy1), .done(done1), .pass(pass1), .fail_code(fc1),
    .match_cnt(mc1), .ign_cnt(ic1), .cycle_cnt(cc1));

  mem_write_checker #(.NUM_EXP(2), .STRICT_ORDER(1)) u2 (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
    .ign_en(ign_en), .start(start), .clear(clear), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .busy(busy2), .done(done2), .pass(pass2), .fail_code(fc2),
    .match_cnt(mc2), .ign_cnt(ic2), .cycle_cnt(cc2));

  mem_write_checker #(.NUM_EXP(2), .STRICT_ORDER(0)) u3 (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
    .ign_en(ign_en), .start(start), .clear(clear), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .busy(busy3), .done(done3), .pass(pass3), .fail_code(fc3),
    .match_cnt(mc3), .ign_cnt(ic3), .cycle_cnt(cc3));

  mem_write_checker #(.NUM_EXP(1), .TIMEOUT_CYC(16)) u4 (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
    .ign_en(ign_en), .start(start), .clear(clear), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .busy(busy4), .done(done4), .pass(pass4), .fail_code(fc4),
    .match_cnt(mc4), .ign_cnt(ic4), .cycle_cnt(cc4));

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; exp_we = 1'b0; start = 1'b0; clear = 1'b0; mem_write = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load(input logic [0:0] idx, input logic [31:0] adr, input logic [31:0] dat);
    exp_we = 1'b1; exp_idx = idx; exp_adr = adr; exp_data = dat;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    mem_write = 1'b1; data_adr = adr; write_data = dat;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_run++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0d want 0", busy1); end
    n_run++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0d want 0", done1); end
    n_run++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %0d want 0", pass1); end
    n_run++; if ({fc1, mc1, ic1, cc1} !== '0) begin n_fail++; $display("FAIL reset_cnt1 got fc=%0d mc=%0d ic=%0d cc=%0d want 0", fc1, mc1, ic1, cc1); end
    n_run++; if ({busy2, done2, pass2, fc2, mc2, ic2, cc2} !== '0) begin n_fail++; $display("FAIL reset_u2 got nonzero outputs want 0"); end
    n_run++; if ({busy3, done3, pass3, fc3, mc3, ic3, cc3} !== '0) begin n_fail++; $display("FAIL reset_u3 got nonzero outputs want 0"); end
    n_run++; if ({busy4, done4, pass4, fc4, mc4, ic4, cc4} !== '0) begin n_fail++; $display("FAIL reset_u4 got nonzero outputs want 0"); end
  endtask

  task automatic test_ignore_then_pass();
    do_reset();
    load(1'b0, 32'd100, 32'd7);
    ign_en = 1'b1;
    arm();
    n_run++; if (busy1 !== 1'b1 || cc1 !== 13'd0) begin n_fail++; $display("FAIL arm_busy got busy=%0d cc=%0d want 1,0", busy1, cc1); end
    wr(32'd96, 32'd5);
    n_run++; if (ic1 !== 8'd1 || mc1 !== 1'b0 || busy1 !== 1'b1) begin n_fail++; $display("FAIL ign_write got ic=%0d mc=%0d busy=%0d want 1,0,1", ic1, mc1, busy1); end
    wr(32'd100, 32'd7);
    n_run++; if (pass1 !== 1'b1 || done1 !== 1'b1 || mc1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL pass_verdict got pass=%0d done=%0d mc=%0d busy=%0d want 1,1,1,0", pass1, done1, mc1, busy1); end
    tick(); tick();
    n_run++; if (cc1 !== 13'd2 || fc1 !== 2'd0) begin n_fail++; $display("FAIL pass_frozen got cc=%0d fc=%0d want 2,0", cc1, fc1); end
  endtask

  task automatic test_data_mismatch();
    clr();
    arm();
    wr(32'd100, 32'd8);
    n_run++; if (fc1 !== 2'd2 || pass1 !== 1'b0 || done1 !== 1'b1) begin n_fail++; $display("FAIL data_mis got fc=%0d pass=%0d done=%0d want 2,0,1", fc1, pass1, done1); end
    wr(32'd100, 32'd7);
    n_run++; if (fc1 !== 2'd2 || mc1 !== 1'b0 || pass1 !== 1'b0) begin n_fail++; $display("FAIL fail_sticky got fc=%0d mc=%0d pass=%0d want 2,0,0", fc1, mc1, pass1); end
    clr();
    ign_en = 1'b0;
    arm();
    wr(32'd96, 32'd0);
    n_run++; if (fc1 !== 2'd1 || ic1 !== 8'd0) begin n_fail++; $display("FAIL ign_disabled got fc=%0d ic=%0d want 1,0", fc1, ic1); end
  endtask

  task automatic test_order();
    do_reset();
    ign_en = 1'b0;
    load(1'b0, 32'd4, 32'd1);
    load(1'b1, 32'd8, 32'd2);
    arm();
    wr(32'd8, 32'd2);
    n_run++; if (fc2 !== 2'd1 || done2 !== 1'b1) begin n_fail++; $display("FAIL strict_ooo got fc=%0d done=%0d want 1,1", fc2, done2); end
    n_run++; if (mc3 !== 2'd1 || busy3 !== 1'b1) begin n_fail++; $display("FAIL any_first got mc=%0d busy=%0d want 1,1", mc3, busy3); end
    wr(32'd4, 32'd1);
    n_run++; if (pass3 !== 1'b1 || mc3 !== 2'd2) begin n_fail++; $display("FAIL any_pass got pass=%0d mc=%0d want 1,2", pass3, mc3); end
    clr();
    arm();
    wr(32'd4, 32'd1);
    wr(32'd8, 32'd2);
    n_run++; if (pass2 !== 1'b1 || mc2 !== 2'd2) begin n_fail++; $display("FAIL strict_pass got pass=%0d mc=%0d want 1,2", pass2, mc2); end
    clr();
    arm();
    wr(32'd8, 32'd2);
    wr(32'd8, 32'd2);
    n_run++; if (fc3 !== 2'd1 || mc3 !== 2'd1 || pass3 !== 1'b0) begin n_fail++; $display("FAIL any_rehit got fc=%0d mc=%0d pass=%0d want 1,1,0", fc3, mc3, pass3); end
  endtask

  task automatic test_timeout();
    do_reset();
    load(1'b0, 32'd100, 32'd7);
    arm();
    for (int i = 0; i < 15; i++) tick();
    n_run++; if (done4 !== 1'b0 || cc4 !== 5'd15) begin n_fail++; $display("FAIL tmo_early got done=%0d cc=%0d want 0,15", done4, cc4); end
    tick();
    n_run++; if (done4 !== 1'b1 || fc4 !== 2'd3 || pass4 !== 1'b0) begin n_fail++; $display("FAIL tmo_fire got done=%0d fc=%0d pass=%0d want 1,3,0", done4, fc4, pass4); end
    clr();
    arm();
    for (int i = 0; i < 15; i++) tick();
    wr(32'd100, 32'd7);
    n_run++; if (pass4 !== 1'b1 || fc4 !== 2'd0) begin n_fail++; $display("FAIL tmo_pass_wins got pass=%0d fc=%0d want 1,0", pass4, fc4); end
  endtask

  task automatic test_abort();
    do_reset();
    load(1'b0, 32'd100, 32'd7);
    ign_en = 1'b1;
    arm();
    wr(32'd96, 32'd0);
    reset = 1'b0;
    #1;
    n_run++; if ({busy1, done1, pass1, fc1, mc1, ic1, cc1} !== '0) begin n_fail++; $display("FAIL async_reset got busy=%0d ic=%0d cc=%0d want 0", busy1, ic1, cc1); end
    reset = 1'b1;
    tick();
    arm();
    wr(32'd100, 32'd7);
    n_run++; if (pass1 !== 1'b1) begin n_fail++; $display("FAIL reset_table_kept got pass=%0d want 1", pass1); end
    clr();
    arm();
    wr(32'd96, 32'd0);
    clear = 1'b1; mem_write = 1'b1; data_adr = 32'd100; write_data = 32'd7;
    tick();
    clear = 1'b0; mem_write = 1'b0;
    n_run++; if ({busy1, done1, pass1, fc1, mc1, ic1, cc1} !== '0) begin n_fail++; $display("FAIL clear_prio got busy=%0d pass=%0d ic=%0d cc=%0d want 0", busy1, pass1, ic1, cc1); end
    arm();
    n_run++; if (busy1 !== 1'b1 || cc1 !== 13'd0) begin n_fail++; $display("FAIL rearm got busy=%0d cc=%0d want 1,0", busy1, cc1); end
    wr(32'd100, 32'd7);
    n_run++; if (pass1 !== 1'b1 || cc1 !== 13'd1) begin n_fail++; $display("FAIL rearm_pass got pass=%0d cc=%0d want 1,1", pass1, cc1); end
  endtask

  task automatic test_ignored_controls();
    arm();
    n_run++; if (pass1 !== 1'b1 || busy1 !== 1'b0 || cc1 !== 13'd1) begin n_fail++; $display("FAIL start_in_pass got pass=%0d busy=%0d cc=%0d want 1,0,1", pass1, busy1, cc1); end
    clr();
    arm();
    load(1'b0, 32'd55, 32'd55);
    wr(32'd100, 32'd7);
    n_run++; if (pass1 !== 1'b1 || mc1 !== 1'b1) begin n_fail++; $display("FAIL we_in_armed got pass=%0d mc=%0d want 1,1", pass1, mc1); end
    clr();
    arm();
    wr(32'd55, 32'd55);
    n_run++; if (fc1 !== 2'd1) begin n_fail++; $display("FAIL table_unchanged got fc=%0d want 1", fc1); end
    clr();
    exp_we = 1'b1; exp_idx = 1'b0; exp_adr = 32'd100; exp_data = 32'd9; start = 1'b1;
    tick();
    exp_we = 1'b0; start = 1'b0;
    wr(32'd100, 32'd9);
    n_run++; if (pass1 !== 1'b1 || fc1 !== 2'd0) begin n_fail++; $display("FAIL we_start_same got pass=%0d fc=%0d want 1,0", pass1, fc1); end
  endtask

  initial begin
    test_reset();
    test_ignore_then_pass();
    test_data_mismatch();
    test_order();
    test_timeout();
    test_abort();
    test_ignored_controls();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
